alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one `alu` instance between two requesters: requester 0 is the execute pipeline, requester 1 is an auxiliary unit (address-gen/CSR helper).
- Each request carries operands and an ALU op. The block arbitrates round-robin, computes the result, and holds it in a one-entry output register.
- Results return to the owning requester over a valid/ready response channel.
- Sits in the execute stage, between the operand muxes and the `alu`.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CNT_WIDTH, 16, width of the contention counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  request 0 accepted this cycle.
- req0_a  in  DATA_WIDTH  operand a.
- req0_b  in  DATA_WIDTH  operand b.
- req0_op  in  4  ALU op encoding.
- req0_f3b0  in  1  funct3 bit0 (branch-compare inversion).
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_f3b0: same as requester 0.
- rsp0_valid  out  1  result pending for requester 0.
- rsp0_ready  in  1  requester 0 takes its result.
- rsp1_valid  out  1  result pending for requester 1.
- rsp1_ready  in  1  requester 1 takes its result.
- rsp_data  out  DATA_WIDTH  registered result, shared by both requesters; valid only with the owner's rspN_valid.
- rsp_err  out  1  registered; set when the captured op was illegal.
- contention_cnt  out  CNT_WIDTH  saturating count of cycles in which both reqN_valid were high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - out_valid=0, rsp_data=0, rsp_err=0, owner=0, contention_cnt=0.
  - last_grant=1, so requester 0 wins the first tie.
- Grant (combinational):
  - Only one reqN_valid high: that requester is granted.
  - Both high: grant = ~last_grant.
  - Neither high: no grant.
- slot_free = ~out_valid | (owner==0 ? rsp0_ready : rsp1_ready).
- reqN_ready = slot_free & reqN_valid & grant==N.
  - Ready may depend on the requester's own valid.
  - Requesters must not wait for ready before asserting valid.
- Accept (reqN_valid & reqN_ready at a rising edge):
  - Granted operands and op drive the `alu` combinationally.
  - Result captures into rsp_data; owner<=N, out_valid<=1, last_grant<=N.
  - Latency: accept at edge k gives rspN_valid high from edge k onward (one cycle).
- Drain without a new accept: out_valid clears on the edge where the owner's rspN_ready is high.
- Simultaneous drain + accept: back-to-back is allowed. The new result overwrites in the same edge, so throughput is 1/cycle with no bubble.
- Response stall: while the owner holds rspN_ready low, rsp_data, rsp_err and owner stay stable, and both reqN_ready stay 0.
  - This includes the case where the non-owner has a valid request.
- rspN_valid = out_valid & owner==N. The non-owner's rspN_ready is ignored.
- Illegal op (4'b1110, 4'b1111):
  - The request is still accepted.
  - rsp_data captured as 0 (never the ALU's x), rsp_err=1.
  - rsp_err for legal ops is 0.
- Branch-compare ops (1010/1011/1100) pass reqN_f3b0 through; their result is 0 or 1.
- contention_cnt:
  - Increments on every edge where req0_valid & req1_valid, regardless of ready.
  - Holds at all-ones (no wrap).
- Requester valid dropping without acceptance is legal and has no side effects.
- Reset mid-operation: a pending result is discarded with no response, and round-robin state returns to the reset values.

Decomposition:
- Shared package alu_pkg:
  - Op encoding localparams: ALU_ADD=0000, ALU_SUB=0001, ALU_SLL=0010, ALU_SLT=0011, ALU_SLTU=0100, ALU_XOR=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_OR=1000, ALU_AND=1001, ALU_BEQ=1010, ALU_BLTU=1011, ALU_BLT=1100, ALU_PASSB=1101.
  - ALU_OP_MAX=1101.
  - Requester-ID localparams.
- One sub-module instance: the existing `alu`.
- The grant mux and output register live in this module; no further hierarchy.

Test Plan:
- Single request: req0 ADD a=5 b=7 with rsp0_ready=1 -> req0_ready same cycle, next cycle rsp0_valid=1, rsp_data=12, rsp_err=0, rsp1_valid=0.
- Tie, then alternation: both valid every cycle, req0 SUB 10-3, req1 XOR F0^0F, both rsp_ready=1 -> grants 0,1,0,1. Results 7, FF alternate owners back-to-back with no bubble. contention_cnt increments each cycle.
- Backpressure: req1 SRA a=0x80000000 b=4 accepted, rsp1_ready=0 for 3 cycles while req0 valid -> rsp_data=0xF8000000 held stable, req0_ready=0 all 3 cycles. When rsp1_ready rises, req0 is accepted that same edge.
- Illegal op: req0 op=1111 -> accepted, rsp_data=0, rsp_err=1. A following legal PASSB with b=0x1234 -> rsp_data=0x1234, rsp_err=0.
- Branch compare: req1 op=1010 a=b=9 with f3b0=0 -> 1; with f3b0=1 -> 0. op=1100 a=-1 b=0 with f3b0=0 -> 1.
- Reset mid-op: accept req0, assert rst_n=0 while rsp0_ready=0 -> rsp0_valid=0 immediately (async). After release, a tie grants requester 0 first. contention_cnt=0. Separately, force CNT_WIDTH=2 and drive both valid for 5 cycles -> contention_cnt saturates at 3.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : ALU op encodings and requester IDs shared by the execute-stage
//               ALU and its two-requester arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_AND    = 4'b1001;
    localparam logic [3:0] ALU_BEQ    = 4'b1010;
    localparam logic [3:0] ALU_BLTU   = 4'b1011;
    localparam logic [3:0] ALU_BLT    = 4'b1100;
    localparam logic [3:0] ALU_PASSB  = 4'b1101;
    localparam logic [3:0] ALU_OP_MAX = 4'b1101;

    // Requester 0 is the execute pipeline, requester 1 the auxiliary unit.
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= ALU_OP_MAX);
    endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Combinational integer ALU with branch-compare support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            op,
    input  logic                  f3b0,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal
);

    localparam int c_SHW = $clog2(DATA_WIDTH);

    logic [c_SHW-1:0] w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_eq;

    assign w_shamt = b[c_SHW-1:0];
    assign w_lt_s  = ($signed(a) < $signed(b));
    assign w_lt_u  = (a < b);
    assign w_eq    = (a == b);

    // Compares return 0/1; f3b0 inverts the branch-compare sense.
    always_comb begin
        result  = '0;
        illegal = !op_is_legal(op);
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << w_shamt;
            ALU_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, w_lt_s};
            ALU_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, w_lt_u};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> w_shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> w_shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_BEQ:   result = {{(DATA_WIDTH-1){1'b0}}, w_eq ^ f3b0};
            ALU_BLTU:  result = {{(DATA_WIDTH-1){1'b0}}, w_lt_u ^ f3b0};
            ALU_BLT:   result = {{(DATA_WIDTH-1){1'b0}}, w_lt_s ^ f3b0};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule : alu

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one ALU between two requesters with a
//               one-entry registered valid/ready response slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [3:0]            req0_op,
    input  logic                  req0_f3b0,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [3:0]            req1_op,
    input  logic                  req1_f3b0,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [CNT_WIDTH-1:0]  contention_cnt
);

    logic                  r_out_valid;
    logic                  r_owner;
    logic                  r_last_grant;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_both;
    logic                  w_grant_id;
    logic                  w_slot_free;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_alu_a;
    logic [DATA_WIDTH-1:0] w_alu_b;
    logic [3:0]            w_alu_op;
    logic                  w_alu_f3b0;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_alu_illegal;

    assign w_both = req0_valid & req1_valid;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        w_grant_id = REQ_ID0;
        if (w_both) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = REQ_ID1;
        end
    end

    assign w_slot_free = ~r_out_valid | ((r_owner == REQ_ID0) ? rsp0_ready : rsp1_ready);
    assign req0_ready  = w_slot_free & req0_valid & (w_grant_id == REQ_ID0);
    assign req1_ready  = w_slot_free & req1_valid & (w_grant_id == REQ_ID1);
    assign w_accept    = req0_ready | req1_ready;

    always_comb begin
        w_alu_a    = req0_a;
        w_alu_b    = req0_b;
        w_alu_op   = req0_op;
        w_alu_f3b0 = req0_f3b0;
        if (w_grant_id == REQ_ID1) begin
            w_alu_a    = req1_a;
            w_alu_b    = req1_b;
            w_alu_op   = req1_op;
            w_alu_f3b0 = req1_f3b0;
        end
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a       (w_alu_a),
        .b       (w_alu_b),
        .op      (w_alu_op),
        .f3b0    (w_alu_f3b0),
        .result  (w_alu_result),
        .illegal (w_alu_illegal)
    );

    // A drain and a new accept on the same edge simply overwrite the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_owner      <= REQ_ID0;
            r_last_grant <= REQ_ID1;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_owner      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_rsp_data   <= w_alu_illegal ? '0 : w_alu_result;
            r_rsp_err    <= w_alu_illegal;
        end else if (w_slot_free) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_both && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign rsp0_valid     = r_out_valid & (r_owner == REQ_ID0);
    assign rsp1_valid     = r_out_valid & (r_owner == REQ_ID1);
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;
    assign contention_cnt = r_cnt;

endmodule : alu_share_arbiter

`default_nettype wire
